// File: rtl/long_div_sign_adapter_if.sv
// Request/response and divider-side signals of the signed-division adapter.
//   start, op, dividend, divisor      : request from the client
//   busy, done, result, error         : status and result back to the client
//   div_start, div_numerator,
//   div_denominator                   : command to the unsigned divider
//   div_done, div_quotient,
//   div_remainder                     : response from the unsigned divider
// slave  : view taken by the adapter itself
// master : view taken by the surrounding client/divider environment
interface long_div_sign_adapter_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  start;
    logic [1:0]            op;
    logic [DATA_WIDTH-1:0] dividend;
    logic [DATA_WIDTH-1:0] divisor;
    logic                  busy;
    logic                  done;
    logic [DATA_WIDTH-1:0] result;
    logic                  error;
    logic                  div_start;
    logic [DATA_WIDTH-1:0] div_numerator;
    logic [DATA_WIDTH-1:0] div_denominator;
    logic                  div_done;
    logic [DATA_WIDTH-1:0] div_quotient;
    logic [DATA_WIDTH-1:0] div_remainder;

    modport slave (
        input  start, op, dividend, divisor,
        input  div_done, div_quotient, div_remainder,
        output busy, done, result, error,
        output div_start, div_numerator, div_denominator
    );

    modport master (
        output start, op, dividend, divisor,
        output div_done, div_quotient, div_remainder,
        input  busy, done, result, error,
        input  div_start, div_numerator, div_denominator
    );
endinterface

// File: rtl/long_div_sign_adapter.sv
// Wraps an external unsigned divider so it can serve DIV/DIVU/REM/REMU.
// Operand magnitudes go to the divider; the sign is re-applied afterwards.
// Divide-by-zero and signed overflow are answered locally without the divider.
// Ports:
//   clk, reset_n : clock (rising edge) and asynchronous active-low reset
//   bus          : long_div_sign_adapter_if.slave (client request/response and
//                  unsigned-divider command/response)
//
// state   | meaning
// --------+---------------------------------------------------------------
// S_IDLE  | waiting for start; operands captured when it arrives
// S_ISSUE | div_start high for this single cycle
// S_WAIT  | waiting on div_done, timeout down-counter running
// S_FIXUP | sign correction / special-case select, result registered
module long_div_sign_adapter #(
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 63
) (
    input  logic                     clk,
    input  logic                     reset_n,
    long_div_sign_adapter_if.slave   bus
);

    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] TIMER_LOAD = TW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
    localparam logic [DATA_WIDTH-1:0] MIN_VAL = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    localparam logic [DATA_WIDTH-1:0] ONES    = '1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_ISSUE = 2'b01,
        S_WAIT  = 2'b10,
        S_FIXUP = 2'b11
    } state_t;

    state_t                state_q, state_d;

    logic [1:0]            op_q;
    logic                  dvd_neg_q, dvs_neg_q;
    logic                  zero_q, ovf_q;
    logic [DATA_WIDTH-1:0] num_q, den_q;
    logic [DATA_WIDTH-1:0] quo_q, rem_q;
    logic [TW-1:0]         timer_q;
    logic [DATA_WIDTH-1:0] result_q;
    logic                  done_q, error_q;

    // Request-side decode, used only when a start is accepted.
    // op[0]=0 selects the signed variants (DIV, REM).
    logic                  in_signed, in_dvd_neg, in_dvs_neg, in_zero, in_ovf;
    logic [DATA_WIDTH-1:0] in_num, in_den;

    always_comb begin
        in_signed  = ~bus.op[0];
        in_dvd_neg = in_signed & bus.dividend[DATA_WIDTH-1];
        in_dvs_neg = in_signed & bus.divisor[DATA_WIDTH-1];
        // Negating MIN_VAL yields MIN_VAL, which is the correct unsigned magnitude.
        in_num     = in_dvd_neg ? -bus.dividend : bus.dividend;
        in_den     = in_dvs_neg ? -bus.divisor  : bus.divisor;
        in_zero    = (bus.divisor == '0);
        in_ovf     = in_signed && (bus.dividend == MIN_VAL) && (bus.divisor == ONES);
    end

    logic accept, timeout;

    always_comb begin
        accept  = (state_q == S_IDLE) && bus.start;
        timeout = (state_q == S_WAIT) && !bus.div_done && (timer_q == '0);
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d = (in_zero || in_ovf) ? S_FIXUP : S_ISSUE;
                end
            end
            S_ISSUE: state_d = S_WAIT;
            S_WAIT: begin
                if (bus.div_done) begin
                    state_d = S_FIXUP;
                end else if (timer_q == '0) begin
                    state_d = S_IDLE;
                end
            end
            S_FIXUP: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Sign correction. For a zero divisor the remainder source is the dividend
    // magnitude; re-applying the dividend sign restores the original dividend.
    logic                  is_signed_q, is_rem_q;
    logic [DATA_WIDTH-1:0] rem_src, quo_fix, rem_fix, fix_val;

    always_comb begin
        is_signed_q = ~op_q[0];
        is_rem_q    = op_q[1];
        rem_src     = zero_q ? num_q : rem_q;
        quo_fix     = (is_signed_q && (dvd_neg_q ^ dvs_neg_q)) ? -quo_q : quo_q;
        rem_fix     = (is_signed_q && dvd_neg_q) ? -rem_src : rem_src;
        fix_val     = '0;
        if (is_rem_q) begin
            fix_val = ovf_q ? '0 : rem_fix;
        end else if (zero_q) begin
            fix_val = ONES;
        end else if (ovf_q) begin
            fix_val = MIN_VAL;
        end else begin
            fix_val = quo_fix;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            op_q      <= '0;
            dvd_neg_q <= 1'b0;
            dvs_neg_q <= 1'b0;
            zero_q    <= 1'b0;
            ovf_q     <= 1'b0;
            num_q     <= '0;
            den_q     <= '0;
            quo_q     <= '0;
            rem_q     <= '0;
            timer_q   <= '0;
            result_q  <= '0;
            done_q    <= 1'b0;
            error_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= (state_q == S_FIXUP);

            if (accept) begin
                op_q      <= bus.op;
                dvd_neg_q <= in_dvd_neg;
                dvs_neg_q <= in_dvs_neg;
                zero_q    <= in_zero;
                ovf_q     <= in_ovf;
                num_q     <= in_num;
                den_q     <= in_den;
                error_q   <= 1'b0;
            end

            if (state_q == S_ISSUE) begin
                timer_q <= TIMER_LOAD;
            end else if ((state_q == S_WAIT) && !bus.div_done && (timer_q != '0)) begin
                timer_q <= timer_q - 1'b1;
            end

            if ((state_q == S_WAIT) && bus.div_done) begin
                quo_q <= bus.div_quotient;
                rem_q <= bus.div_remainder;
            end

            if (timeout) begin
                error_q <= 1'b1;
            end

            if (state_q == S_FIXUP) begin
                result_q <= fix_val;
            end
        end
    end

    assign bus.busy            = (state_q != S_IDLE);
    assign bus.div_start       = (state_q == S_ISSUE);
    assign bus.div_numerator   = num_q;
    assign bus.div_denominator = den_q;
    assign bus.done            = done_q;
    assign bus.result          = result_q;
    assign bus.error           = error_q;

endmodule

// File: tb/tb_long_div_sign_adapter.sv
// Directed-vector bench for long_div_sign_adapter with a bench-side unsigned
// divider stub and an arithmetic reference model of the four operations.
module tb_long_div_sign_adapter;

    localparam int DW      = 32;
    localparam int TIMEOUT = 63;
    localparam int NEVER   = 32'h3fffffff;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    long_div_sign_adapter_if #(.DATA_WIDTH(DW)) bus ();

    long_div_sign_adapter #(
        .DATA_WIDTH    (DW),
        .TIMEOUT_CYCLES(TIMEOUT)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
        end
    endtask

    // Reference model: plain signed/unsigned arithmetic plus the two special cases.
    function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        logic ovf;
        ovf = (a == 32'h80000000) && (b == 32'hFFFFFFFF);
        case (op)
            2'b00:   model = (b == 0) ? 32'hFFFFFFFF : ovf ? 32'h80000000 : 32'($signed(a) / $signed(b));
            2'b01:   model = (b == 0) ? 32'hFFFFFFFF : a / b;
            2'b10:   model = (b == 0) ? a : ovf ? 32'h0 : 32'($signed(a) % $signed(b));
            default: model = (b == 0) ? a : a % b;
        endcase
    endfunction

    typedef struct {
        int          done_cyc;
        logic [31:0] res;
        logic [31:0] hand;
    } exp_t;
    exp_t exp_q[$];

    int          busy_lo = -1, busy_hi = -2;
    int          ds_cyc  = -1;
    int          err_lo  = NEVER, err_hi = NEVER;
    logic [31:0] exp_result = '0;
    int          lat = 1;
    logic [31:0] exp_num = '0, exp_den = '0;
    int          last_k = 0, last_done = 0;

    // Compare process: every cycle, #1 after the rising edge.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            while (exp_q.size() > 0 && exp_q[0].done_cyc < cyc) void'(exp_q.pop_front());
            if (exp_q.size() > 0 && exp_q[0].done_cyc == cyc) begin
                chk("done", {31'b0, bus.done}, 32'd1);
                exp_result = exp_q[0].res;
                chk("result_hand", bus.result, exp_q[0].hand);
                void'(exp_q.pop_front());
            end else begin
                chk("done", {31'b0, bus.done}, 32'd0);
            end
            chk("result", bus.result, exp_result);
            chk("busy", {31'b0, bus.busy}, {31'b0, (cyc >= busy_lo && cyc <= busy_hi)});
            chk("div_start", {31'b0, bus.div_start}, {31'b0, (cyc == ds_cyc)});
            chk("error", {31'b0, bus.error}, {31'b0, (cyc >= err_lo && cyc <= err_hi)});
        end
    end

    // Unsigned divider stub: answers lat cycles after div_start; lat<0 never answers.
    initial begin
        logic [31:0] snum, sden;
        bus.div_done      = 1'b0;
        bus.div_quotient  = '0;
        bus.div_remainder = '0;
        forever begin
            @(negedge clk);
            if (bus.div_start === 1'b1) begin
                snum = bus.div_numerator;
                sden = bus.div_denominator;
                chk("div_numerator", snum, exp_num);
                chk("div_denominator", sden, exp_den);
                if (lat >= 0) begin
                    for (int i = 0; i < lat; i++) begin
                        @(negedge clk);
                        if (bus.busy) chk("num_stable", bus.div_numerator, snum);
                    end
                    bus.div_done      = 1'b1;
                    bus.div_quotient  = snum / sden;
                    bus.div_remainder = snum % sden;
                    @(negedge clk);
                    bus.div_done      = 1'b0;
                end
            end
        end
    end

    // Call at a falling edge; drives start for one cycle and records expectations.
    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input int l, input logic [31:0] hand);
        int  k;
        logic bypass;
        k       = cyc;
        last_k  = k;
        bypass  = (b == 0) || (!op[0] && a == 32'h80000000 && b == 32'hFFFFFFFF);
        lat     = l;
        exp_num = (!op[0] && a[31]) ? -a : a;
        exp_den = (!op[0] && b[31]) ? -b : b;
        if (err_lo <= k && err_hi > k) err_hi = k;
        busy_lo = k + 1;
        ds_cyc  = bypass ? -1 : k + 1;
        if (bypass) begin
            last_done = k + 2;
        end else if (l < 0) begin
            last_done = k + 2 + TIMEOUT;
            err_lo    = k + 2 + TIMEOUT;
            err_hi    = NEVER;
        end else begin
            last_done = k + 3 + l;
        end
        busy_hi = last_done - 1;
        if (bypass || l >= 0) exp_q.push_back('{last_done, model(op, a, b), hand});
        bus.start    = 1'b1;
        bus.op       = op;
        bus.dividend = a;
        bus.divisor  = b;
        @(negedge clk);
        bus.start    = 1'b0;
        bus.dividend = 32'hDEADBEEF;
        bus.divisor  = 32'h0000_0003;
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hand;
        int          l;
    } vec_t;
    vec_t vecs[$];

    initial begin
        #100000;
        errors++;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        bus.start    = 1'b0;
        bus.op       = 2'b00;
        bus.dividend = '0;
        bus.divisor  = '0;

        vecs.push_back('{2'b00, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, 3});
        vecs.push_back('{2'b10, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 2});
        vecs.push_back('{2'b01, 32'hFFFFFFFF, 32'h00000010, 32'h0FFFFFFF, 1});
        vecs.push_back('{2'b11, 32'hFFFFFFFF, 32'h00000010, 32'h0000000F, 4});
        vecs.push_back('{2'b00, 32'h00000007, 32'hFFFFFFFE, 32'hFFFFFFFD, 5});
        vecs.push_back('{2'b10, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 2});
        vecs.push_back('{2'b00, 32'h00000005, 32'h00000000, 32'hFFFFFFFF, 1});
        vecs.push_back('{2'b10, 32'h00000005, 32'h00000000, 32'h00000005, 1});
        vecs.push_back('{2'b01, 32'h00000005, 32'h00000000, 32'hFFFFFFFF, 1});
        vecs.push_back('{2'b11, 32'h80000000, 32'h00000000, 32'h80000000, 1});
        vecs.push_back('{2'b10, 32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 1});
        vecs.push_back('{2'b00, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1});
        vecs.push_back('{2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1});
        vecs.push_back('{2'b01, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 2});
        vecs.push_back('{2'b11, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1});
        vecs.push_back('{2'b10, 32'hFFFFFFF8, 32'h00000003, 32'hFFFFFFFE, 1});
        vecs.push_back('{2'b00, 32'hFFFFFFF8, 32'hFFFFFFFD, 32'h00000002, 3});

        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        foreach (vecs[i]) begin
            issue(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].l, vecs[i].hand);
            wait_until(last_done);
            @(negedge clk);
        end

        // Back-to-back: the next start lands in the cycle done is high.
        issue(2'b00, 32'd100, 32'd7, 2, 32'd14);
        wait_until(last_done);
        issue(2'b10, 32'hFFFFFF9C, 32'd7, 1, 32'hFFFFFFFE);
        wait_until(last_done);
        issue(2'b00, 32'd9, 32'd0, 1, 32'hFFFFFFFF);
        wait_until(last_done);
        @(negedge clk);

        // Start pulsed during WAIT with different operands must be ignored.
        issue(2'b01, 32'd1000, 32'd9, 6, 32'd111);
        @(negedge clk);
        @(negedge clk);
        bus.start    = 1'b1;
        bus.op       = 2'b10;
        bus.dividend = 32'd1;
        bus.divisor  = 32'd0;
        @(negedge clk);
        bus.start    = 1'b0;
        wait_until(last_done);
        @(negedge clk);

        // Reset mid-WAIT: no done, stale div_done afterwards ignored.
        issue(2'b00, 32'd100, 32'd7, 8, 32'd14);
        wait_until(last_k + 4);
        reset_n = 1'b0;
        exp_q.delete();
        exp_result = '0;
        busy_hi    = -2;
        ds_cyc     = -1;
        err_lo     = NEVER;
        err_hi     = NEVER;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (8) @(negedge clk);

        // Divider never answers: error after the timeout, then cleared by next start.
        issue(2'b01, 32'd50, 32'd5, -1, 32'd0);
        wait_until(last_done + 3);
        issue(2'b01, 32'd9, 32'd3, 2, 32'd3);
        wait_until(last_done);
        repeat (3) @(negedge clk);

        chk("queue_drained", exp_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
